gcd: RTL and testbench

// - Self-contained micro-sequenced processor that computes GCD(A_INIT, B_INIT) by repeated subtraction.
// - Runs a fixed 13-word program held in an internal ROM, with no data inputs.
// - Raises meow and stays halted once the result is ready.
// - Top-level leaf; the result register gcd_result is read hierarchically by the bench.

---
 rtl/gcd.sv | 195 +++++++++++++++++++
 tb/tb_gcd.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gcd.sv
// gcd: tiny two-phase micro-sequenced processor that computes the greatest
// common divisor of A_INIT and B_INIT by repeated subtraction. The program
// is a fixed 13-word ROM. The processor halts with meow raised once R0
// holds the result.
module gcd #(
   parameter int WIDTH  = 8,
   parameter int A_INIT = 48,
   parameter int B_INIT = 18
) (
   input  logic clk,
   input  logic rst_n,
   output logic meow
);

   // Sequencer states
   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   // Opcodes
   localparam logic [2:0] OP_LDI = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MOV = 3'd2;
   localparam logic [2:0] OP_BZ  = 3'd3;
   localparam logic [2:0] OP_BEQ = 3'd4;
   localparam logic [2:0] OP_BLT = 3'd5;
   localparam logic [2:0] OP_JMP = 3'd6;
   localparam logic [2:0] OP_HLT = 3'd7;

   // Register selectors
   localparam logic [1:0] R0 = 2'd0;
   localparam logic [1:0] R1 = 2'd1;

   // LDI constants, truncated to the datapath width
   localparam logic [WIDTH-1:0] A_K = A_INIT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] B_K = B_INIT[WIDTH-1:0];

   // Instruction word layout:
   // [13:11] op, [10:9] rd, [8:7] ra, [6:5] rb, [4:1] target, [0] ksel (0=A, 1=B)
   function automatic logic [13:0] enc(
      input logic [2:0] op,
      input logic [1:0] rd,
      input logic [1:0] ra,
      input logic [1:0] rb,
      input logic [3:0] tgt,
      input logic       ksel
   );
      enc = {op, rd, ra, rb, tgt, ksel};
   endfunction

   // Fixed program ROM; unused words hold HLT
   function automatic logic [13:0] rom_word(input logic [3:0] addr);
      case (addr)
         4'd0:    rom_word = enc(OP_LDI, R0, R0, R0, 4'd0,  1'b0);
         4'd1:    rom_word = enc(OP_LDI, R1, R0, R0, 4'd0,  1'b1);
         4'd2:    rom_word = enc(OP_BZ,  R0, R1, R0, 4'd10, 1'b0);
         4'd3:    rom_word = enc(OP_BZ,  R0, R0, R0, 4'd11, 1'b0);
         4'd4:    rom_word = enc(OP_BEQ, R0, R0, R1, 4'd10, 1'b0);
         4'd5:    rom_word = enc(OP_BLT, R0, R0, R1, 4'd8,  1'b0);
         4'd6:    rom_word = enc(OP_SUB, R0, R0, R1, 4'd0,  1'b0);
         4'd7:    rom_word = enc(OP_JMP, R0, R0, R0, 4'd4,  1'b0);
         4'd8:    rom_word = enc(OP_SUB, R1, R1, R0, 4'd0,  1'b0);
         4'd9:    rom_word = enc(OP_JMP, R0, R0, R0, 4'd4,  1'b0);
         4'd10:   rom_word = enc(OP_HLT, R0, R0, R0, 4'd0,  1'b0);
         4'd11:   rom_word = enc(OP_MOV, R0, R1, R0, 4'd0,  1'b0);
         4'd12:   rom_word = enc(OP_HLT, R0, R0, R0, 4'd0,  1'b0);
         default: rom_word = enc(OP_HLT, R0, R0, R0, 4'd0,  1'b0);
      endcase
   endfunction

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [3:0]       pc_r;
   logic [3:0]       pc_nxt_s;
   logic [13:0]      ir_r;
   logic [13:0]      ir_nxt_s;
   logic             meow_r;
   logic             meow_nxt_s;
   logic [WIDTH-1:0] regs_r [4];
   logic             wr_en_s;
   logic [WIDTH-1:0] wr_data_s;

   logic [2:0]       op_s;
   logic [1:0]       rd_s;
   logic [1:0]       ra_s;
   logic [1:0]       rb_s;
   logic [3:0]       tgt_s;
   logic             ksel_s;
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;

   logic [WIDTH-1:0] gcd_result;

   assign gcd_result = regs_r[0];
   assign meow       = meow_r;

   assign op_s   = ir_r[13:11];
   assign rd_s   = ir_r[10:9];
   assign ra_s   = ir_r[8:7];
   assign rb_s   = ir_r[6:5];
   assign tgt_s  = ir_r[4:1];
   assign ksel_s = ir_r[0];
   assign a_s    = regs_r[ra_s];
   assign b_s    = regs_r[rb_s];

   // Next-state, program counter, register write and done-flag decode
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      ir_nxt_s    = ir_r;
      meow_nxt_s  = meow_r;
      wr_en_s     = 1'b0;
      wr_data_s   = '0;
      case (state_r)
         ST_FETCH: begin
            ir_nxt_s    = rom_word(pc_r);
            pc_nxt_s    = pc_r + 4'd1;
            state_nxt_s = ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt_s = ST_FETCH;
            case (op_s)
               OP_LDI: begin
                  wr_en_s   = 1'b1;
                  wr_data_s = ksel_s ? B_K : A_K;
               end
               OP_SUB: begin
                  wr_en_s   = 1'b1;
                  wr_data_s = a_s - b_s;
               end
               OP_MOV: begin
                  wr_en_s   = 1'b1;
                  wr_data_s = a_s;
               end
               OP_BZ: begin
                  if (a_s == '0) pc_nxt_s = tgt_s;
                  else           pc_nxt_s = pc_r;
               end
               OP_BEQ: begin
                  if (a_s == b_s) pc_nxt_s = tgt_s;
                  else            pc_nxt_s = pc_r;
               end
               OP_BLT: begin
                  if (a_s < b_s) pc_nxt_s = tgt_s;
                  else           pc_nxt_s = pc_r;
               end
               OP_JMP: begin
                  pc_nxt_s = tgt_s;
               end
               OP_HLT: begin
                  state_nxt_s = ST_HALT;
                  meow_nxt_s  = 1'b1;
               end
               default: begin
                  state_nxt_s = ST_HALT;
                  meow_nxt_s  = 1'b1;
               end
            endcase
         end
         ST_HALT: begin
            state_nxt_s = ST_HALT;
            meow_nxt_s  = 1'b1;
         end
         default: begin
            state_nxt_s = ST_FETCH;
            meow_nxt_s  = 1'b0;
         end
      endcase
   end

   // Sequencer state, pc, instruction register and done flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FETCH;
         pc_r    <= 4'd0;
         ir_r    <= 14'd0;
         meow_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         ir_r    <= ir_nxt_s;
         meow_r  <= meow_nxt_s;
      end
   end

   // Register file R0..R3
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) regs_r[i] <= '0;
      end else if (wr_en_s) begin
         regs_r[rd_s] <= wr_data_s;
      end
   end

endmodule

// File: tb/tb_gcd.sv
// tb_gcd: six gcd instances with different operands share one clock. The
// stimulus process releases resets and pushes the expected results into a
// scoreboard queue. A monitor pops an entry on every rising meow.
module tb_gcd;

   typedef struct {
      int id;
      int res;
      int edge_n;   // expected edge of meow rise; 0 = not checked
   } exp_t;

   logic       clk;
   logic [5:0] rst_v;
   logic [5:0] m;
   logic [7:0] res [6];
   int         cnt [6];
   exp_t       sb [$];
   int         checks;
   int         failures;
   int         hold_cnt;
   bit         hold_active;

   gcd #(.WIDTH(8), .A_INIT(48),  .B_INIT(18)) u0 (.clk(clk), .rst_n(rst_v[0]), .meow(m[0]));
   gcd #(.WIDTH(8), .A_INIT(17),  .B_INIT(5))  u1 (.clk(clk), .rst_n(rst_v[1]), .meow(m[1]));
   gcd #(.WIDTH(8), .A_INIT(0),   .B_INIT(7))  u2 (.clk(clk), .rst_n(rst_v[2]), .meow(m[2]));
   gcd #(.WIDTH(8), .A_INIT(13),  .B_INIT(0))  u3 (.clk(clk), .rst_n(rst_v[3]), .meow(m[3]));
   gcd #(.WIDTH(8), .A_INIT(0),   .B_INIT(0))  u4 (.clk(clk), .rst_n(rst_v[4]), .meow(m[4]));
   gcd #(.WIDTH(8), .A_INIT(255), .B_INIT(1))  u5 (.clk(clk), .rst_n(rst_v[5]), .meow(m[5]));

   assign res[0] = u0.gcd_result;
   assign res[1] = u1.gcd_result;
   assign res[2] = u2.gcd_result;
   assign res[3] = u3.gcd_result;
   assign res[4] = u4.gcd_result;
   assign res[5] = u5.gcd_result;

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Per-instance count of rising edges since reset release
   always @(posedge clk) begin
      for (int i = 0; i < 6; i++) begin
         if (!rst_v[i]) cnt[i] <= 0;
         else           cnt[i] <= cnt[i] + 1;
      end
   end

   // Monitor: compare on every rising meow; also watch the 17,5 halt hold
   initial begin
      logic [5:0] m_prev;
      int         idx;
      m_prev = 6'd0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 6; i++) begin
            if (m[i] && !m_prev[i]) begin
               idx = -1;
               for (int k = 0; k < sb.size(); k++) begin
                  if (idx < 0 && sb[k].id == i) idx = k;
               end
               checks++;
               if (idx < 0) begin
                  failures++;
                  $display("FAIL unexpected_meow dut%0d got rise at edge %0d, expected none", i, cnt[i]);
               end else begin
                  if (res[i] != sb[idx].res[7:0]) begin
                     failures++;
                     $display("FAIL result dut%0d got %0d expected %0d", i, res[i], sb[idx].res);
                  end
                  if (sb[idx].edge_n > 0) begin
                     checks++;
                     if (cnt[i] != sb[idx].edge_n) begin
                        failures++;
                        $display("FAIL meow_edge dut%0d got %0d expected %0d", i, cnt[i], sb[idx].edge_n);
                     end
                  end
                  sb.delete(idx);
               end
               if (i == 1) hold_active = 1'b1;
            end
         end
         if (hold_active && hold_cnt < 100) begin
            checks++;
            if (!(m[1] === 1'b1 && res[1] == 8'd1)) begin
               failures++;
               $display("FAIL halt_hold dut1 cycle %0d got meow=%0b result=%0d expected meow=1 result=1",
                        hold_cnt, m[1], res[1]);
            end
            hold_cnt++;
         end
         m_prev = m;
      end
   end

   // Stimulus
   initial begin
      checks      = 0;
      failures    = 0;
      hold_cnt    = 0;
      hold_active = 1'b0;
      rst_v       = 6'd0;
      repeat (3) @(negedge clk);

      // Reset state
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (m[i] !== 1'b0) begin
            failures++;
            $display("FAIL reset_meow dut%0d got %b expected 0", i, m[i]);
         end
         checks++;
         if (res[i] !== 8'd0) begin
            failures++;
            $display("FAIL reset_result dut%0d got %0d expected 0", i, res[i]);
         end
      end

      // Release all resets; first rising edge is the first fetch
      rst_v = 6'b111111;
      sb.push_back('{id: 1, res: 1,  edge_n: 0});
      sb.push_back('{id: 2, res: 7,  edge_n: 0});
      sb.push_back('{id: 3, res: 13, edge_n: 0});
      sb.push_back('{id: 4, res: 0,  edge_n: 8});
      sb.push_back('{id: 5, res: 1,  edge_n: 0});

      // Abort the 48,18 run at cycle 20 with an asynchronous reset
      repeat (20) @(posedge clk);
      #1 rst_v[0] = 1'b0;
      #1;
      checks++;
      if (m[0] !== 1'b0) begin
         failures++;
         $display("FAIL midrun_reset_meow got %b expected 0", m[0]);
      end
      checks++;
      if (res[0] !== 8'd0) begin
         failures++;
         $display("FAIL midrun_reset_r0 got %0d expected 0", res[0]);
      end
      @(negedge clk);
      @(negedge clk);
      rst_v[0] = 1'b1;
      sb.push_back('{id: 0, res: 6, edge_n: 44});

      // Bounded wait for the scoreboard to drain and the hold window to finish
      for (int c = 0; c < 4000; c++) begin
         if (sb.size() == 0 && hold_cnt >= 100) break;
         @(negedge clk);
      end
      while (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL timeout dut%0d got no meow expected result %0d", sb[0].id, sb[0].res);
         sb.delete(0);
      end
      checks++;
      if (hold_cnt < 100) begin
         failures++;
         $display("FAIL hold_window got %0d cycles expected 100", hold_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
